// File: rtl/slc3_control.sv
// -----------------------------------------------------------------------------
// slc3_control
//   Instruction-sequencing control FSM for the SLC-3 CPU. Drives every load
//   enable, bus gate and mux select of the datapath plus the memory strobes,
//   and steps through fetch / decode / execute for ADD, AND, NOT, BR, JMP, JSR,
//   LDR, STR and PAUSE. Memory accesses are held for MEM_WAIT cycles by a
//   small wait counter.
//
// Parameters
//   MEM_WAIT   cycles each memory read/write is held (legal 1..7)
//
// Ports
//   Clk, Reset            clock, asynchronous active-high reset (to HALTED)
//   Run                   leaves HALTED and starts fetching
//   Continue              releases PAUSE
//   Opcode, IR_5, IR_11   instruction fields from the IR
//   BEN                   branch-enable flag from the datapath
//   LD_*                  datapath register load enables
//   Gate*                 bus drivers (at most one high per cycle)
//   PCMUX, ADDR2MUX, ALUK, ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MARMUX, MIO_EN
//                         datapath mux selects
//   Mem_OE, Mem_WE        memory read / write strobes, active high
//   State                 current state encoding for debug / LEDs
// -----------------------------------------------------------------------------
module slc3_control #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       ADDR1MUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       DRMUX,
    output logic       MARMUX,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [4:0] State
);

    typedef enum logic [4:0] {
        S_HALTED = 5'd0,
        S_FETCH1 = 5'd1,
        S_FETCH2 = 5'd2,
        S_FETCH3 = 5'd3,
        S_DECODE = 5'd4,
        S_ADD    = 5'd5,
        S_AND    = 5'd6,
        S_NOT    = 5'd7,
        S_BR1    = 5'd8,
        S_BR2    = 5'd9,
        S_JMP    = 5'd10,
        S_JSR1   = 5'd11,
        S_JSR2   = 5'd12,
        S_LDR1   = 5'd13,
        S_LDR2   = 5'd14,
        S_LDR3   = 5'd15,
        S_STR1   = 5'd16,
        S_STR2   = 5'd17,
        S_STR3   = 5'd18,
        S_PAUSE1 = 5'd19,
        S_PAUSE2 = 5'd20
    } state_t;

    // Last count value of a memory wait; the wait state exits on this cycle.
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state, next_state;
    logic [2:0] wait_cnt;
    logic       wait_done;
    logic       in_wait;

    assign wait_done = (wait_cnt == WAIT_LAST);
    assign in_wait   = (state == S_FETCH2) || (state == S_LDR2) || (state == S_STR3);
    assign State     = state;
    assign MARMUX    = 1'b0;

    // ---------------- state register ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_HALTED;
        else       state <= next_state;
    end

    // Counter is cleared on every state change, so it is always zero on entry
    // to a wait state and counts only while the FSM dwells there.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                     wait_cnt <= 3'd0;
        else if (next_state != state)  wait_cnt <= 3'd0;
        else if (in_wait)              wait_cnt <= wait_cnt + 3'd1;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            S_HALTED: if (Run) next_state = S_FETCH1;
            S_FETCH1: next_state = S_FETCH2;
            S_FETCH2: if (wait_done) next_state = S_FETCH3;
            S_FETCH3: next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    4'b0001: next_state = S_ADD;
                    4'b0101: next_state = S_AND;
                    4'b1001: next_state = S_NOT;
                    4'b0000: next_state = S_BR1;
                    4'b1100: next_state = S_JMP;
                    4'b0100: next_state = S_JSR1;
                    4'b0110: next_state = S_LDR1;
                    4'b0111: next_state = S_STR1;
                    4'b1101: next_state = S_PAUSE1;
                    default: next_state = S_FETCH1;   // unsupported opcode = NOP
                endcase
            end
            S_ADD, S_AND, S_NOT, S_JMP, S_BR2, S_JSR2, S_LDR3:
                next_state = S_FETCH1;
            S_BR1:    next_state = BEN ? S_BR2 : S_FETCH1;
            S_JSR1:   next_state = S_JSR2;
            S_LDR1:   next_state = S_LDR2;
            S_LDR2:   if (wait_done) next_state = S_LDR3;
            S_STR1:   next_state = S_STR2;
            S_STR2:   next_state = S_STR3;
            S_STR3:   if (wait_done) next_state = S_FETCH1;
            S_PAUSE1: if (Continue) next_state = S_PAUSE2;
            // Wait for release so one press cannot clear two PAUSEs.
            S_PAUSE2: if (!Continue) next_state = S_FETCH1;
            default:  next_state = S_HALTED;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        ADDR1MUX   = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        DRMUX      = 1'b0;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        case (state)
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            S_FETCH2, S_LDR2: begin
                Mem_OE = 1'b1;
                MIO_EN = 1'b1;
                LD_MDR = wait_done;     // capture only once the read has settled
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND: begin
                SR1MUX  = 1'b1;
                SR2MUX  = ~IR_5;
                ALUK    = (state == S_AND) ? 2'b01 : 2'b00;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_NOT: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b10;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_BR2: begin
                LD_PC    = 1'b1;
                PCMUX    = 2'b10;
                ADDR2MUX = 2'b10;
            end
            S_JMP: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            S_JSR1: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            S_JSR2: begin
                LD_PC = 1'b1;
                PCMUX = 2'b10;
                if (IR_11) begin
                    ADDR2MUX = 2'b11;   // JSR: PC + SEXT(IR[10:0])
                end else begin
                    ADDR1MUX = 1'b1;    // JSRR: base register
                    SR1MUX   = 1'b1;
                end
            end
            S_LDR1, S_STR1: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
            end
            S_LDR3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_STR2: begin
                // Source register is IR[11:9]; pass it through the ALU into MDR.
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S_STR3:   Mem_WE = 1'b1;
            S_PAUSE1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slc3_control.sv
module tb_slc3_control;

    // state codes
    localparam logic [4:0] S_HALTED = 5'd0,  S_F1 = 5'd1,  S_F2 = 5'd2,  S_F3 = 5'd3,
                           S_DEC = 5'd4,     S_ADD = 5'd5, S_AND = 5'd6, S_NOT = 5'd7,
                           S_BR1 = 5'd8,     S_BR2 = 5'd9, S_JMP = 5'd10, S_JSR1 = 5'd11,
                           S_JSR2 = 5'd12,   S_LDR1 = 5'd13, S_LDR2 = 5'd14, S_LDR3 = 5'd15,
                           S_STR1 = 5'd16,   S_STR2 = 5'd17, S_STR3 = 5'd18,
                           S_P1 = 5'd19,     S_P2 = 5'd20;

    // output vector bit masks
    localparam logic [25:0] LDMAR = 26'd1 << 25, LDMDR = 26'd1 << 24, LDIR = 26'd1 << 23,
                            LDBEN = 26'd1 << 22, LDCC = 26'd1 << 21,  LDREG = 26'd1 << 20,
                            LDPC = 26'd1 << 19,  LDLED = 26'd1 << 18, GPC = 26'd1 << 17,
                            GMDR = 26'd1 << 16,  GALU = 26'd1 << 15,  GMARM = 26'd1 << 14,
                            PC_ADR = 26'd2 << 12,
                            A2_01 = 26'd1 << 10, A2_10 = 26'd2 << 10, A2_11 = 26'd3 << 10,
                            ALU_AND = 26'd1 << 8, ALU_NOT = 26'd2 << 8, ALU_PASS = 26'd3 << 8,
                            A1 = 26'd1 << 7, SR1 = 26'd1 << 6, SR2 = 26'd1 << 5,
                            DR = 26'd1 << 4, MIO = 26'd1 << 2, OE = 26'd1 << 1, WE = 26'd1;

    logic       clk, rst, run, cont, ir5, ir11, ben;
    logic [3:0] opcode;
    wire  [25:0] o_a, o_b;
    wire  [4:0]  st_a, st_b;
    logic       sel;   // 0: check dut_a (MEM_WAIT=2), 1: dut_b (MEM_WAIT=3)

    typedef struct packed {
        logic [4:0]  st;
        logic [25:0] o;
    } exp_t;
    exp_t q[$];

    int passes = 0;
    int total  = 0;

    slc3_control #(.MEM_WAIT(2)) dut_a (
        .Clk(clk), .Reset(rst), .Run(run), .Continue(cont), .Opcode(opcode),
        .IR_5(ir5), .IR_11(ir11), .BEN(ben),
        .LD_MAR(o_a[25]), .LD_MDR(o_a[24]), .LD_IR(o_a[23]), .LD_BEN(o_a[22]),
        .LD_CC(o_a[21]), .LD_REG(o_a[20]), .LD_PC(o_a[19]), .LD_LED(o_a[18]),
        .GatePC(o_a[17]), .GateMDR(o_a[16]), .GateALU(o_a[15]), .GateMARMUX(o_a[14]),
        .PCMUX(o_a[13:12]), .ADDR2MUX(o_a[11:10]), .ALUK(o_a[9:8]),
        .ADDR1MUX(o_a[7]), .SR1MUX(o_a[6]), .SR2MUX(o_a[5]), .DRMUX(o_a[4]),
        .MARMUX(o_a[3]), .MIO_EN(o_a[2]), .Mem_OE(o_a[1]), .Mem_WE(o_a[0]),
        .State(st_a)
    );

    slc3_control #(.MEM_WAIT(3)) dut_b (
        .Clk(clk), .Reset(rst), .Run(run), .Continue(cont), .Opcode(opcode),
        .IR_5(ir5), .IR_11(ir11), .BEN(ben),
        .LD_MAR(o_b[25]), .LD_MDR(o_b[24]), .LD_IR(o_b[23]), .LD_BEN(o_b[22]),
        .LD_CC(o_b[21]), .LD_REG(o_b[20]), .LD_PC(o_b[19]), .LD_LED(o_b[18]),
        .GatePC(o_b[17]), .GateMDR(o_b[16]), .GateALU(o_b[15]), .GateMARMUX(o_b[14]),
        .PCMUX(o_b[13:12]), .ADDR2MUX(o_b[11:10]), .ALUK(o_b[9:8]),
        .ADDR1MUX(o_b[7]), .SR1MUX(o_b[6]), .SR2MUX(o_b[5]), .DRMUX(o_b[4]),
        .MARMUX(o_b[3]), .MIO_EN(o_b[2]), .Mem_OE(o_b[1]), .Mem_WE(o_b[0]),
        .State(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) passes++;
        else $error("FAIL %s got=%h want=%h", tag, got, want);
    endtask

    // Bus gates of the checked DUT must never overlap.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert ($countones(sel ? o_b[17:14] : o_a[17:14]) <= 1) passes++;
            else $error("FAIL gate_onehot got=%b want=at most one", sel ? o_b[17:14] : o_a[17:14]);
        end
    end

    task automatic push(input logic [4:0] s, input logic [25:0] o);
        exp_t e;
        e.st = s;
        e.o  = o;
        q.push_back(e);
    endtask

    task automatic push_fetch(input int mw);
        push(S_F1, LDMAR | LDPC | GPC);
        for (int i = 0; i < mw; i++)
            push(S_F2, MIO | OE | ((i == mw - 1) ? LDMDR : 26'd0));
        push(S_F3, GMDR | LDIR);
        push(S_DEC, LDBEN);
    endtask

    // Enter FETCH1 on the next edge, then present the instruction fields.
    task automatic begin_instr(input logic [3:0] op, input logic i5, input logic i11,
                               input logic b, input int mw);
        @(posedge clk);
        #1;
        opcode = op; ir5 = i5; ir11 = i11; ben = b; run = 1'b0;
        push_fetch(mw);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (q.size() != 0) begin
            @(negedge clk);
            e = q.pop_front();
            chk({tag, "_state"}, 32'(sel ? st_b : st_a), 32'(e.st));
            chk({tag, "_outs"},  32'(sel ? o_b : o_a),   32'(e.o));
        end
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1; run = 1'b0; cont = 1'b0;
        opcode = 4'h0; ir5 = 1'b0; ir11 = 1'b0; ben = 1'b0;

        // reset state
        @(posedge clk); #1;
        chk("reset_state", 32'(st_a), 32'(S_HALTED));
        chk("reset_outs",  32'(o_a), 32'd0);
        @(negedge clk); rst = 1'b0;

        // HALTED holds with Run low
        for (int i = 0; i < 10; i++) push(S_HALTED, 26'd0);
        drain("halted");

        run = 1'b1;
        begin_instr(4'b0001, 1'b1, 1'b0, 1'b0, 2);          // ADD imm
        push(S_ADD, SR1 | GALU | LDREG | LDCC);
        drain("add");

        begin_instr(4'b0101, 1'b0, 1'b0, 1'b0, 2);          // AND reg
        push(S_AND, SR1 | SR2 | ALU_AND | GALU | LDREG | LDCC);
        drain("and");

        begin_instr(4'b1001, 1'b0, 1'b0, 1'b0, 2);          // NOT
        push(S_NOT, SR1 | ALU_NOT | GALU | LDREG | LDCC);
        drain("not");

        begin_instr(4'b0000, 1'b0, 1'b0, 1'b0, 2);          // BR not taken
        push(S_BR1, 26'd0);
        drain("br_nt");

        begin_instr(4'b0000, 1'b0, 1'b0, 1'b1, 2);          // BR taken
        push(S_BR1, 26'd0);
        push(S_BR2, LDPC | PC_ADR | A2_10);
        drain("br_t");

        begin_instr(4'b1100, 1'b0, 1'b0, 1'b0, 2);          // JMP
        push(S_JMP, SR1 | A1 | PC_ADR | LDPC);
        drain("jmp");

        begin_instr(4'b0100, 1'b0, 1'b1, 1'b0, 2);          // JSR
        push(S_JSR1, GPC | DR | LDREG);
        push(S_JSR2, LDPC | PC_ADR | A2_11);
        drain("jsr");

        begin_instr(4'b0100, 1'b0, 1'b0, 1'b0, 2);          // JSRR
        push(S_JSR1, GPC | DR | LDREG);
        push(S_JSR2, LDPC | PC_ADR | A1 | SR1);
        drain("jsrr");

        begin_instr(4'b0110, 1'b0, 1'b0, 1'b0, 2);          // LDR
        push(S_LDR1, GMARM | LDMAR | SR1 | A1 | A2_01);
        push(S_LDR2, MIO | OE);
        push(S_LDR2, MIO | OE | LDMDR);
        push(S_LDR3, GMDR | LDREG | LDCC);
        drain("ldr");

        begin_instr(4'b0111, 1'b0, 1'b0, 1'b0, 2);          // STR, 2-cycle write
        push(S_STR1, GMARM | LDMAR | SR1 | A1 | A2_01);
        push(S_STR2, ALU_PASS | GALU | LDMDR);
        push(S_STR3, WE);
        push(S_STR3, WE);
        drain("str2");

        begin_instr(4'b1111, 1'b0, 1'b0, 1'b0, 2);          // NOP, DECODE -> FETCH1
        drain("nop");

        begin_instr(4'b1101, 1'b0, 1'b0, 1'b0, 2);          // PAUSE
        push(S_P1, LDLED);
        push(S_P1, LDLED);
        drain("pause1");
        cont = 1'b1;
        push(S_P2, 26'd0);
        push(S_P2, 26'd0);
        push(S_P2, 26'd0);
        drain("pause2");
        cont = 1'b0;

        // Reset in the middle of a fetch read: strobes drop without a clock.
        begin_instr(4'b0001, 1'b1, 1'b0, 1'b0, 2);
        q.delete();
        push(S_F1, LDMAR | LDPC | GPC);
        push(S_F2, MIO | OE);
        drain("mid_f2");
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(st_a), 32'(S_HALTED));
        chk("async_rst_oe",    32'(o_a[1]), 32'd0);
        chk("async_rst_outs",  32'(o_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(S_HALTED, 26'd0);
        push(S_HALTED, 26'd0);
        drain("post_rst");

        // STR on the MEM_WAIT=3 instance.
        sel = 1'b1;
        run = 1'b1;
        begin_instr(4'b0111, 1'b0, 1'b0, 1'b0, 3);
        push(S_STR1, GMARM | LDMAR | SR1 | A1 | A2_01);
        push(S_STR2, ALU_PASS | GALU | LDMDR);
        push(S_STR3, WE);
        push(S_STR3, WE);
        push(S_STR3, WE);
        push(S_F1, LDMAR | LDPC | GPC);
        drain("str3");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
